ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Turns the PS/2 set-2 scan-code byte stream from the keyboard receiver into the key signals consumed by the screen renderer and player logic.
- Produces one-cycle press pulses `key_enter` and `key_space`, which dismiss the start screen.
- Produces held-level movement keys for both players: fire uses the arrow keys, water uses W/A/D.
- Sits between the PS/2 byte receiver and the screen/game-state logic, in the clk domain.

Parameters:
- TIMEOUT_CYCLES, 650000: idle cycles after a prefix byte before the pending sequence is abandoned (used only with the optional feature; ~10 ms at 65 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  scan-code byte from the PS/2 receiver
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
- clear_keys  in  1  level; forces all held keys released (game-state use on lose/restart)
- key_enter  out  1  one-cycle pulse on Enter press (main 0x5A or keypad E0 5A)
- key_space  out  1  one-cycle pulse on Space press (0x29)
- fire_left  out  1  held: Left arrow (E0 6B)
- fire_right  out  1  held: Right arrow (E0 74)
- fire_up  out  1  held: Up arrow (E0 75)
- water_left  out  1  held: A (0x1C)
- water_right  out  1  held: D (0x23)
- water_up  out  1  held: W (0x1D)

Behaviour:
- Reset: every output is 0; FSM in IDLE; internal enter_held and space_held are 0.
- FSM states: IDLE, EXT (E0 received), BRK (F0 received), EXT_BRK (E0 then F0). Transitions occur only on rx_valid:
  - 0xE0 in any state -> EXT.
  - 0xF0: from IDLE -> BRK; from EXT -> EXT_BRK; from BRK or EXT_BRK -> stay.
  - Any other byte completes the sequence. Make/break is decided by the state (BRK and EXT_BRK mean break), and extended/normal by EXT or EXT_BRK. The key table is applied, then the FSM returns to IDLE.
  - Unrecognised codes, including 0xE1 and the 0xAA BAT code, are ignored and the FSM returns to IDLE.
- Key table, normal: 5A Enter, 29 Space, 1C A, 23 D, 1D W.
- Key table, extended: 5A Enter, 6B Left, 74 Right, 75 Up.
  - A normal code received in an extended state is not aliased. Example: E0 1C is ignored.
- Held levels: set on make, cleared on break. They are registered and change the cycle after the completing rx_valid (latency 1).
- Pulses:
  - `key_enter` is high for exactly one cycle, the cycle after a make completes, only if enter_held was 0. enter_held is then set.
  - Break clears enter_held.
  - Typematic repeat makes (held key re-sent) produce no further pulses.
  - `key_space` follows the same rules using space_held.
- `clear_keys` high:
  - All held outputs, enter_held and space_held go to 0 next cycle.
  - FSM -> IDLE.
  - A byte arriving with rx_valid in the same cycle is discarded.
  - Pulses are suppressed that cycle.
- A break for a key not currently held has no effect.
- Main and keypad Enter share one enter_held flag.
- rx_valid on consecutive cycles is legal: one byte is processed per cycle.

Optional Feature:
- Macro: PS2_KEYDEC_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is in EXT, BRK or EXT_BRK with no rx_valid.
  - It resets to 0 on every rx_valid and in IDLE.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE and the partial sequence is dropped. Held outputs are unchanged.
- Not defined:
  - No counter and no TIMEOUT_CYCLES logic; prefix states persist until the next byte.

Decomposition:
- Package ps2_key_pkg holds:
  - the scan-code localparams (SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ENTER=8'h5A, SC_SPACE=8'h29, SC_A=8'h1C, SC_D=8'h23, SC_W=8'h1D, SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_UP=8'h75);
  - the FSM state enum typedef.
- Optional sub-module ps2_prefix_fsm holds the state register and the optional timeout counter. It exposes the completed byte plus is_ext/is_break flags and a done strobe. The top level owns the key table, held registers and pulse generation.

Test Plan:
- After reset, send 5A -> key_enter=1 for exactly 1 cycle, one cycle after rx_valid. Then send 5A 5A (repeat) -> no pulse. Then F0 5A, then 5A -> exactly one new pulse.
- Send E0 6B -> fire_left=1. Send 1C -> water_left=1. Send E0 F0 6B -> fire_left=0 while water_left stays 1.
- Send 29 then E0 5A -> key_space pulse, then key_enter pulse. Then F0 5A (main break) -> enter_held cleared; a new E0 5A pulses again.
- Hold 1D and E0 75, pulse clear_keys in the same cycle as rx_valid with 0x23 -> all held outputs 0 next cycle; water_right never asserts.
- Send E0 1C, then E1, then AA -> no output changes, FSM back in IDLE. A following 23 sets water_right=1.
- With PS2_KEYDEC_TIMEOUT_EN and TIMEOUT_CYCLES=16: send F0, wait 20 cycles, send 1D -> water_up=1, because the break was abandoned. The same sequence without the macro -> water_up stays 0.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants and prefix-state encoding for the PS/2 key decoder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ps2_key_pkg;

  // Prefix bytes of the set-2 protocol.
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Keys the game cares about.
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;

  // Where we are inside a multi-byte make/break sequence.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  // A prefix byte only advances the state machine; anything else completes a sequence.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_prefix_fsm.sv
// Tracks E0/F0 prefixes and flags the byte that completes each scan-code sequence.
// Latency: combinational done/code/flags in the cycle of the completing rx_valid.
// Backpressure: none; one byte accepted per cycle. Optional macro: PS2_KEYDEC_TIMEOUT_EN.
module ps2_prefix_fsm
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_done,
  output logic [7:0] o_code,
  output logic       o_is_ext,
  output logic       o_is_break
);

  ps2_state_t r_state;
  ps2_state_t w_state_nxt;
  logic       w_timeout;

  // A timeout shorter than two cycles would abandon every prefix immediately.
  a_timeout_min : assert property (@(posedge clk) TIMEOUT_CYCLES >= 2);

`ifdef PS2_KEYDEC_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Stalled-prefix detector: counts quiet cycles spent waiting for the rest of a sequence.
  assign w_timeout = (r_state != ST_IDLE) && (r_cnt == CNT_LAST);

  // Quiet-cycle counter; any byte, flush or return to IDLE restarts it.
  always_ff @(posedge clk) begin
    if (rst || i_flush || i_rx_valid || (r_state == ST_IDLE) || w_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  // Without the timeout a prefix waits indefinitely for its next byte.
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and completion strobe; a flush drops the byte in flight.
  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else if (i_rx_valid) begin
      if (i_rx_data == SC_EXT) begin
        // E0 restarts an extended sequence from any state.
        w_state_nxt = ST_EXT;
      end else if (i_rx_data == SC_BRK) begin
        unique case (r_state)
          ST_IDLE: w_state_nxt = ST_BRK;
          ST_EXT:  w_state_nxt = ST_EXT_BRK;
          default: w_state_nxt = r_state;
        endcase
      end else begin
        // Every non-prefix byte ends the sequence, recognised or not.
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end
  end

  assign o_code     = i_rx_data;
  assign o_is_ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign o_is_break = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 set-2 scan codes into Enter/Space press pulses and held movement keys.
// Latency: 1 cycle from the completing rx_valid to pulse/held-level change.
// Backpressure: none; one byte per cycle, clear_keys discards the byte in the same cycle. Optional macro: PS2_KEYDEC_TIMEOUT_EN.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear_keys,
  output logic       key_enter,
  output logic       key_space,
  output logic       fire_left,
  output logic       fire_right,
  output logic       fire_up,
  output logic       water_left,
  output logic       water_right,
  output logic       water_up
);

  logic       w_done;
  logic [7:0] w_code;
  logic       w_is_ext;
  logic       w_is_break;

  ps2_prefix_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_prefix (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (clear_keys),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_done     (w_done),
    .o_code     (w_code),
    .o_is_ext   (w_is_ext),
    .o_is_break (w_is_break)
  );

  logic w_hit_enter;
  logic w_hit_space;
  logic w_hit_a;
  logic w_hit_d;
  logic w_hit_w;
  logic w_hit_left;
  logic w_hit_right;
  logic w_hit_up;

  // Key table: Enter matches both main and keypad; other codes only in their own table.
  always_comb begin
    w_hit_enter = 1'b0;
    w_hit_space = 1'b0;
    w_hit_a     = 1'b0;
    w_hit_d     = 1'b0;
    w_hit_w     = 1'b0;
    w_hit_left  = 1'b0;
    w_hit_right = 1'b0;
    w_hit_up    = 1'b0;
    if (w_done) begin
      w_hit_enter = (w_code == SC_ENTER);
      if (w_is_ext) begin
        w_hit_left  = (w_code == SC_LEFT);
        w_hit_right = (w_code == SC_RIGHT);
        w_hit_up    = (w_code == SC_UP);
      end else begin
        w_hit_space = (w_code == SC_SPACE);
        w_hit_a     = (w_code == SC_A);
        w_hit_d     = (w_code == SC_D);
        w_hit_w     = (w_code == SC_W);
      end
    end
  end

  logic r_key_enter;
  logic r_key_space;
  logic r_enter_held;
  logic r_space_held;

  // Press pulses fire only on the first make; typematic repeats see the held flag and stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_enter  <= 1'b0;
      r_key_space  <= 1'b0;
      r_enter_held <= 1'b0;
      r_space_held <= 1'b0;
    end else begin
      r_key_enter <= 1'b0;
      r_key_space <= 1'b0;
      if (clear_keys) begin
        r_enter_held <= 1'b0;
        r_space_held <= 1'b0;
      end else begin
        if (w_hit_enter) begin
          if (w_is_break) begin
            r_enter_held <= 1'b0;
          end else begin
            r_key_enter  <= ~r_enter_held;
            r_enter_held <= 1'b1;
          end
        end
        if (w_hit_space) begin
          if (w_is_break) begin
            r_space_held <= 1'b0;
          end else begin
            r_key_space  <= ~r_space_held;
            r_space_held <= 1'b1;
          end
        end
      end
    end
  end

  logic r_fire_left;
  logic r_fire_right;
  logic r_fire_up;
  logic r_water_left;
  logic r_water_right;
  logic r_water_up;

  // Movement levels follow make/break; a break for an unheld key just rewrites 0.
  always_ff @(posedge clk) begin
    if (rst || clear_keys) begin
      r_fire_left   <= 1'b0;
      r_fire_right  <= 1'b0;
      r_fire_up     <= 1'b0;
      r_water_left  <= 1'b0;
      r_water_right <= 1'b0;
      r_water_up    <= 1'b0;
    end else begin
      if (w_hit_left)  r_fire_left   <= ~w_is_break;
      if (w_hit_right) r_fire_right  <= ~w_is_break;
      if (w_hit_up)    r_fire_up     <= ~w_is_break;
      if (w_hit_a)     r_water_left  <= ~w_is_break;
      if (w_hit_d)     r_water_right <= ~w_is_break;
      if (w_hit_w)     r_water_up    <= ~w_is_break;
    end
  end

  assign key_enter   = r_key_enter;
  assign key_space   = r_key_space;
  assign fire_left   = r_fire_left;
  assign fire_right  = r_fire_right;
  assign fire_up     = r_fire_up;
  assign water_left  = r_water_left;
  assign water_right = r_water_right;
  assign water_up    = r_water_up;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed byte vectors with hand-computed output vectors.
// Output vector bit order: {enter, space, fire_l, fire_r, fire_u, water_l, water_r, water_u}.
// Every cycle with no due expectation must show the last held levels with both pulses low.
module tb_ps2_key_decoder;

  localparam logic [7:0] EN = 8'h80;
  localparam logic [7:0] SP = 8'h40;
  localparam logic [7:0] FL = 8'h20;
  localparam logic [7:0] FU = 8'h08;
  localparam logic [7:0] WL = 8'h04;
  localparam logic [7:0] WR = 8'h02;
  localparam logic [7:0] WU = 8'h01;

`ifdef PS2_KEYDEC_TIMEOUT_EN
  localparam logic [7:0] TO_EXP = WU;
`else
  localparam logic [7:0] TO_EXP = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clear_keys = 1'b0;
  logic       key_enter, key_space;
  logic       fire_left, fire_right, fire_up;
  logic       water_left, water_right, water_up;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .clear_keys  (clear_keys),
    .key_enter   (key_enter),
    .key_space   (key_space),
    .fire_left   (fire_left),
    .fire_right  (fire_right),
    .fire_up     (fire_up),
    .water_left  (water_left),
    .water_right (water_right),
    .water_up    (water_up)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] v;
    string      name;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic [7:0] steady = 8'h00;
  logic [7:0] w_vec;

  assign w_vec = {key_enter, key_space, fire_left, fire_right, fire_up,
                  water_left, water_right, water_up};

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%02h expected=%02h", nm, cyc, got, exp);
    end
  endtask

  // Monitor: compares against a due expectation, otherwise against the held levels.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check(e.name, w_vec, e.v);
        steady = e.v & 8'h3F;
      end else begin
        check("steady", w_vec, steady);
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic clr, input logic [7:0] exp,
                       input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rx_data    = b;
    rx_valid   = 1'b1;
    clear_keys = clr;
    e.due  = cyc + 1;
    e.v    = exp;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rx_valid   = 1'b0;
      clear_keys = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset", w_vec, 8'h00);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Enter press, typematic repeats, release, fresh press.
    drive(8'h5A, 0, EN,   "enter_make");
    idle(2);
    drive(8'h5A, 0, 8'h00, "enter_repeat1");
    drive(8'h5A, 0, 8'h00, "enter_repeat2");
    drive(8'hF0, 0, 8'h00, "brk_prefix");
    drive(8'h5A, 0, 8'h00, "enter_break");
    drive(8'h5A, 0, EN,   "enter_remake");
    idle(2);

    // Arrow and letter holds; extended break releases only the arrow.
    drive(8'hE0, 0, 8'h00,  "ext_prefix");
    drive(8'h6B, 0, FL,     "left_make");
    drive(8'h1C, 0, FL|WL,  "a_make");
    drive(8'hE0, 0, FL|WL,  "ext_prefix2");
    drive(8'hF0, 0, FL|WL,  "ext_brk_prefix");
    drive(8'h6B, 0, WL,     "left_break");
    idle(2);

    // Release Enter, then Space pulse, keypad Enter pulse, main break, keypad re-press.
    drive(8'hF0, 0, WL,     "brk_prefix2");
    drive(8'h5A, 0, WL,     "enter_break2");
    drive(8'h29, 0, SP|WL,  "space_make");
    drive(8'hE0, 0, WL,     "ext_prefix3");
    drive(8'h5A, 0, EN|WL,  "kp_enter_make");
    drive(8'hF0, 0, WL,     "brk_prefix3");
    drive(8'h5A, 0, WL,     "main_enter_break");
    drive(8'hE0, 0, WL,     "ext_prefix4");
    drive(8'h5A, 0, EN|WL,  "kp_enter_remake");
    idle(2);

    // Hold W and Up, then clear_keys with D arriving in the same cycle.
    drive(8'h1D, 0, WL|WU,    "w_make");
    drive(8'hE0, 0, WL|WU,    "ext_prefix5");
    drive(8'h75, 0, WL|WU|FU, "up_make");
    drive(8'h23, 1, 8'h00,    "clear_with_d");
    idle(3);
    drive(8'h29, 0, SP,       "space_after_clear");
    idle(2);

    // Aliased and unrecognised codes change nothing; D then works normally.
    drive(8'hE0, 0, 8'h00, "ext_prefix6");
    drive(8'h1C, 0, 8'h00, "ext_a_alias");
    drive(8'hE1, 0, 8'h00, "code_e1");
    drive(8'hAA, 0, 8'h00, "code_bat");
    drive(8'h23, 0, WR,    "d_make");
    idle(2);

    // Repeated F0 keeps the break state.
    drive(8'hF0, 0, WR,    "brk_prefix4");
    drive(8'hF0, 0, WR,    "brk_prefix5");
    drive(8'h23, 0, 8'h00, "d_break");
    idle(2);

    // Abandoned break: W is a make only when the prefix timeout is built in.
    drive(8'hF0, 0, 8'h00, "brk_prefix6");
    idle(20);
    drive(8'h1D, 0, TO_EXP, "w_after_wait");
    idle(5);

    check("queue_drain", 8'(q.size()), 8'h00);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
